ds_dac_mod: RTL and testbench

- Second-order delta-sigma DAC modulator: signed PCM samples in, 1-bit oversampled stream out on a PMOD pin, external RC low-pass filter.
- Transmit-side counterpart of the comparator-based delta-sigma ADC path: it generates the bitstream where the ADC path consumes one.
- Sits between the signed-16-bit sample domain (after ADC latch / processing) and a PMOD output pin, in the single MMCM clock domain.

---
 rtl/ds_dac_mod.sv | 159 +++++++++++++++
 tb/tb_ds_dac_mod.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/ds_dac_mod.sv
// Second-order CIFB delta-sigma DAC modulator: one-entry sample buffer, OSR phase counter, 1-bit output.
// Optional +/-1 LSB LFSR dither on the modulator input when DS_DAC_DITHER_EN is defined.
module ds_dac_mod #(
  parameter int W     = 16,
  parameter int OSR   = 64,
  parameter int ACC_W = 20,
  parameter int CLIP  = 24576
) (
  input  logic                clk,
  input  logic                rst,
  input  logic signed [W-1:0] din,
  input  logic                din_valid,
  output logic                din_ready,
  output logic                dout,
  output logic                sample_tick,
  output logic                underrun,
  output logic                clip,
  output logic                ovl
);

  localparam int CNT_W = (OSR > 1) ? $clog2(OSR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OSR - 1);
  // Two guard bits cover i + in + fb before saturation.
  localparam int SUM_W = ACC_W + 2;

  localparam logic signed [W-1:0]     CLIP_HI = W'(CLIP);
  localparam logic signed [W-1:0]     CLIP_LO = -CLIP_HI;
  localparam logic signed [SUM_W-1:0] SAT_HI  = {{3{1'b0}}, {(ACC_W-1){1'b1}}};
  localparam logic signed [SUM_W-1:0] SAT_LO  = -SAT_HI;
  localparam logic signed [SUM_W-1:0] FB_P    = {{(SUM_W-W){1'b0}}, 1'b1, {(W-1){1'b0}}};
  localparam logic signed [SUM_W-1:0] FB_N    = -FB_P;

  function automatic logic signed [W-1:0] clamp_in(input logic signed [W-1:0] x);
    if (x > CLIP_HI) return CLIP_HI;
    if (x < CLIP_LO) return CLIP_LO;
    return x;
  endfunction

  function automatic logic sat_hit(input logic signed [SUM_W-1:0] x);
    return (x > SAT_HI) || (x < SAT_LO);
  endfunction

  function automatic logic signed [ACC_W-1:0] sat_acc(input logic signed [SUM_W-1:0] x);
    logic signed [SUM_W-1:0] y;
    y = x;
    if (x > SAT_HI) y = SAT_HI;
    if (x < SAT_LO) y = SAT_LO;
    return y[ACC_W-1:0];
  endfunction

  logic [CNT_W-1:0]        r_cnt;
  logic signed [W-1:0]     r_buf;
  logic                    r_buf_full;
  logic signed [W-1:0]     r_active;
  logic                    r_tick;
  logic                    r_underrun;
  logic                    r_clip;
  logic signed [ACC_W-1:0] r_i1;
  logic signed [ACC_W-1:0] r_i2;
  logic                    r_dout;
  logic                    r_ovl;

  logic                    w_wrap;
  logic                    w_capture;
  logic signed [W-1:0]     w_clamped;
  logic                    w_clip_hit;
  logic signed [SUM_W-1:0] w_act_ext;
  logic signed [SUM_W-1:0] w_mod_in;
  logic signed [SUM_W-1:0] w_fb;
  logic signed [SUM_W-1:0] w_i1_ext;
  logic signed [SUM_W-1:0] w_i2_ext;
  logic signed [SUM_W-1:0] w_i1_sum;
  logic signed [SUM_W-1:0] w_i2_sum;
  logic signed [ACC_W-1:0] w_i1_next;
  logic signed [ACC_W-1:0] w_i2_next;

  assign w_wrap     = (r_cnt == CNT_LAST);
  assign w_capture  = din_valid && !r_buf_full;
  assign w_clamped  = clamp_in(din);
  assign w_clip_hit = (w_clamped != din);

  // Buffer, phase counter and sample hand-over
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt      <= '0;
      r_buf      <= '0;
      r_buf_full <= 1'b0;
      r_active   <= '0;
      r_tick     <= 1'b0;
      r_underrun <= 1'b0;
      r_clip     <= 1'b0;
    end else begin
      r_cnt      <= w_wrap ? '0 : r_cnt + 1'b1;
      r_tick     <= w_wrap && r_buf_full;
      r_underrun <= w_wrap && !r_buf_full;
      r_clip     <= w_capture && w_clip_hit;
      if (w_wrap && r_buf_full) begin
        r_active   <= r_buf;
        r_buf_full <= 1'b0;
      end else if (w_capture) begin
        r_buf      <= w_clamped;
        r_buf_full <= 1'b1;
      end
    end
  end

  assign w_act_ext = {{(SUM_W-W){r_active[W-1]}}, r_active};

`ifdef DS_DAC_DITHER_EN
  localparam logic signed [SUM_W-1:0] DITH_P = {{(SUM_W-1){1'b0}}, 1'b1};
  localparam logic signed [SUM_W-1:0] DITH_N = -DITH_P;

  logic [15:0] r_lfsr;
  logic        w_lfsr_fb;

  assign w_lfsr_fb = r_lfsr[15] ^ r_lfsr[13] ^ r_lfsr[12] ^ r_lfsr[10];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) r_lfsr <= 16'hACE1;
    else      r_lfsr <= {r_lfsr[14:0], w_lfsr_fb};
  end

  assign w_mod_in = w_act_ext + (r_lfsr[0] ? DITH_P : DITH_N);
`else
  assign w_mod_in = w_act_ext;
`endif

  assign w_fb      = r_dout ? FB_P : FB_N;
  assign w_i1_ext  = {{(SUM_W-ACC_W){r_i1[ACC_W-1]}}, r_i1};
  assign w_i2_ext  = {{(SUM_W-ACC_W){r_i2[ACC_W-1]}}, r_i2};
  // Second integrator takes the old i1, giving the two-clock input-to-output latency.
  assign w_i1_sum  = w_i1_ext + w_mod_in - w_fb;
  assign w_i2_sum  = w_i2_ext + w_i1_ext - w_fb;
  assign w_i1_next = sat_acc(w_i1_sum);
  assign w_i2_next = sat_acc(w_i2_sum);

  // Loop state and quantizer
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_i1   <= '0;
      r_i2   <= '0;
      r_dout <= 1'b0;
      r_ovl  <= 1'b0;
    end else begin
      r_i1   <= w_i1_next;
      r_i2   <= w_i2_next;
      r_dout <= !w_i2_next[ACC_W-1];
      r_ovl  <= sat_hit(w_i1_sum) || sat_hit(w_i2_sum);
    end
  end

  assign din_ready   = !r_buf_full;
  assign dout        = r_dout;
  assign sample_tick = r_tick;
  assign underrun    = r_underrun;
  assign clip        = r_clip;
  assign ovl         = r_ovl;

endmodule

// File: tb/tb_ds_dac_mod.sv
// Directed bench for ds_dac_mod: reset state, DC density, clamping, underrun, handshake and async reset.
module tb_ds_dac_mod;
  localparam int W   = 16;
  localparam int OSR = 64;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic signed [W-1:0] din = '0;
  logic                din_valid = 1'b0;
  logic                din_ready;
  logic                dout;
  logic                sample_tick;
  logic                underrun;
  logic                clip;
  logic                ovl;

  ds_dac_mod #(.W(W), .OSR(OSR), .ACC_W(20), .CLIP(24576)) dut (
    .clk(clk), .rst(rst), .din(din), .din_valid(din_valid), .din_ready(din_ready),
    .dout(dout), .sample_tick(sample_tick), .underrun(underrun), .clip(clip), .ovl(ovl)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_pass = 0;
  int n_ones, n_tick, n_und, n_clip, n_ovl, n_acc;
  bit inc_mode = 1'b0;
  int c;

  task automatic chk(input string tag, input int obs, input int exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_chk++;
    assert (obs >= lo && obs <= hi) n_pass++;
    else $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
  endtask

  task automatic clr();
    n_ones = 0; n_tick = 0; n_und = 0; n_clip = 0; n_ovl = 0; n_acc = 0;
  endtask

  task automatic cyc();
    bit acc;
    acc = din_valid && din_ready;
    @(posedge clk);
    #1;
    if (acc) begin
      n_acc++;
      if (inc_mode) din = din + 16'sd1;
    end
    if (dout)        n_ones++;
    if (sample_tick) n_tick++;
    if (underrun)    n_und++;
    if (clip)        n_clip++;
    if (ovl)         n_ovl++;
  endtask

  task automatic wait_tick(input string tag, output int cycles);
    cycles = 0;
    do begin
      cyc();
      cycles++;
    end while (!sample_tick && cycles < 200);
    chk(tag, int'(sample_tick), 1);
  endtask

  task automatic measure();
    cyc();
    cyc();
    clr();
    repeat (4096) cyc();
  endtask

  task automatic do_reset();
    @(posedge clk);
    #3 rst = 1'b0;
    #3 rst = 1'b1;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    clr();
    #1 rst = 1'b0;
    #1;
    chk("rst_ready", int'(din_ready), 1);
    chk("rst_dout", int'(dout), 0);
    chk("rst_tick", int'(sample_tick), 0);
    chk("rst_underrun", int'(underrun), 0);
    chk("rst_clip", int'(clip), 0);
    chk("rst_ovl", int'(ovl), 0);
    #10 rst = 1'b1;

    // Zero input: half density, first tick 64 clocks after capture
    din = 16'sd0; din_valid = 1'b1;
    wait_tick("z_tick", c);
    chk("z_latency", c, 64);
    measure();
    chk_rng("z_ones", n_ones, 2044, 2052);
    chk("z_ovl", n_ovl, 0);
    chk("z_clip", n_clip, 0);
    chk("z_underrun", n_und, 0);

    do_reset();
    din = 16'sd16384; din_valid = 1'b1;
    wait_tick("p_tick", c);
    measure();
    chk_rng("p_ones", n_ones, 3068, 3076);
    chk("p_ovl", n_ovl, 0);

    do_reset();
    din = -16'sd16384; din_valid = 1'b1;
    wait_tick("n_tick", c);
    measure();
    chk_rng("n_ones", n_ones, 1020, 1028);
    chk("n_ovl", n_ovl, 0);

    // Positive clamp, then a single sample with underruns afterwards
    do_reset();
    din = 16'sd32767; din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    chk("cp_pulse", int'(clip), 1);
    wait_tick("cp_tick", c);
    chk("cp_active", int'(dut.r_active), 24576);
    measure();
    chk_rng("cp_ones", n_ones, 3576, 3592);
    chk("cp_ovl", n_ovl, 0);
    chk("cp_clip_again", n_clip, 0);
    chk("cp_underruns", n_und, 64);
    chk("cp_ticks", n_tick, 0);
    chk("cp_active_held", int'(dut.r_active), 24576);

    do_reset();
    din = -16'sd32768; din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    chk("cn_pulse", int'(clip), 1);
    wait_tick("cn_tick", c);
    chk("cn_active", int'(dut.r_active), -24576);

    do_reset();
    din = -16'sd24576; din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    chk("cb_no_pulse", int'(clip), 0);
    wait_tick("cb_tick", c);
    chk("cb_active", int'(dut.r_active), -24576);

    // Handshake with continuously valid, incrementing samples
    do_reset();
    din = 16'sd100; din_valid = 1'b1; inc_mode = 1'b1;
    clr();
    for (int k = 0; k < 6; k++) begin
      wait_tick("hs_tick", c);
      chk("hs_active", int'(dut.r_active), 100 + k);
      chk("hs_ready_up", int'(din_ready), 1);
      cyc();
      chk("hs_ready_down", int'(din_ready), 0);
    end
    chk("hs_accepts", n_acc, 7);
    chk("hs_underrun", n_und, 0);
    chk("hs_next_din", int'(din), 107);
    inc_mode = 1'b0; din_valid = 1'b0;

    // Capture coinciding with an empty-buffer wrap
    wait_tick("ec_tick0", c);
    chk("ec_active0", int'(dut.r_active), 106);
    repeat (63) cyc();
    din = 16'sd555; din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    chk("ec_underrun", int'(underrun), 1);
    chk("ec_no_tick", int'(sample_tick), 0);
    chk("ec_ready", int'(din_ready), 0);
    wait_tick("ec_tick1", c);
    chk("ec_latency", c, 64);
    chk("ec_active1", int'(dut.r_active), 555);

    // Asynchronous reset mid-sample with a full buffer
    do_reset();
    din = 16'sd500; din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    repeat (29) cyc();
    chk("ar_cnt", int'(dut.r_cnt), 30);
    chk("ar_full", int'(din_ready), 0);
    #2 rst = 1'b0;
    #1;
    chk("ar_ready", int'(din_ready), 1);
    chk("ar_dout", int'(dout), 0);
    chk("ar_tick", int'(sample_tick), 0);
    chk("ar_underrun", int'(underrun), 0);
    chk("ar_ovl", int'(ovl), 0);
    chk("ar_active", int'(dut.r_active), 0);
    #2 rst = 1'b1;
    din = 16'sd777; din_valid = 1'b1;
    cyc();
    din_valid = 1'b0;
    wait_tick("ar_tick1", c);
    chk("ar_latency", c + 1, 64);
    chk("ar_new_active", int'(dut.r_active), 777);
    clr();
    repeat (128) cyc();
    chk("ar_no_old_tick", n_tick, 0);
    chk("ar_active_kept", int'(dut.r_active), 777);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
